// File: rtl/eth_frame_loop_pkg.sv
// Shared types and constants for the frame loop receive path.
// Optional TTL decrement is enabled in the top with LOOP_TTL_DEC_EN.
package eth_frame_loop_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETH_TYPE_VLAN   = 16'h8100;
    localparam logic [15:0] IP_OFF_UNTAGGED = 16'd14;
    localparam logic [15:0] IP_OFF_TAGGED   = 16'd18;
    localparam logic [15:0] IP_CSUM_OFF     = 16'd10;
    localparam logic [15:0] IP_TTL_OFF      = 16'd8;

    typedef struct packed {
        logic [15:0] csum;
        logic [14:0] pos;
        logic        fix;
    } csum_desc_t;

    typedef enum logic {ST_FRAME, ST_FOLD} state_t;

    // 16-bit word index of the IPv4 checksum field inside the frame
    function automatic logic [14:0] csum_pos(input logic [15:0] ip_off);
        return 15'((ip_off + IP_CSUM_OFF) >> 1);
    endfunction

endpackage

// File: rtl/eth_csum_fold.sv
// One's-complement fold of a 21-bit checksum accumulator down to 16 bits.
module eth_csum_fold (
    input  logic [20:0] acc,
    output logic [15:0] sum
);
    logic [16:0] step1;

    // Second fold can no longer carry out, so 16 bits suffice.
    always_comb begin
        step1 = {1'b0, acc[15:0]} + {12'd0, acc[20:16]};
        sum   = step1[15:0] + {15'd0, step1[16]};
    end
endmodule

// File: rtl/eth_frame_loop_rx.sv
// Frame loop ingress: byte passthrough with on-the-fly IPv4 header checksum recompute.
// Define LOOP_TTL_DEC_EN to forward (and sum) the IPv4 TTL decremented by one.
module eth_frame_loop_rx
    import eth_frame_loop_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE_IPV4 = ETH_TYPE_IPV4,
    parameter logic [15:0] ETHERTYPE_VLAN = ETH_TYPE_VLAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_frame_tdata,
    output logic        m_axis_frame_tuser,
    output logic        m_axis_frame_tlast,
    output logic        m_axis_frame_tvalid,
    input  logic        m_axis_frame_tready,
    output logic [31:0] m_axis_csum_tdata,
    output logic        m_axis_csum_tvalid,
    input  logic        m_axis_csum_tready
);
    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [20:0] acc;
    logic [15:0] etype;
    logic        vlan, ip_ok, hdr_done, err;
    logic [3:0]  ihl;
    csum_desc_t  desc, desc_nx;
    logic        desc_full;

    logic        beat;
    logic [15:0] ip_off, hdr_idx, hdr_len, add_word;
    logic        in_hdr, fix;
    logic [7:0]  byte_fwd;
    logic [15:0] fold_sum, csum;

    assign s_axis_tready = rst_n & m_axis_frame_tready & (state == ST_FRAME)
                         & ~(s_axis_tlast & desc_full & ~m_axis_csum_tready);
    assign beat = s_axis_tvalid & s_axis_tready;

    assign m_axis_frame_tdata  = byte_fwd;
    assign m_axis_frame_tuser  = s_axis_tuser;
    assign m_axis_frame_tlast  = s_axis_tlast;
    assign m_axis_frame_tvalid = beat;
    assign m_axis_csum_tdata   = desc;
    assign m_axis_csum_tvalid  = desc_full;

    // Header position tracking; the first header byte is summed before IHL is known.
    always_comb begin
        ip_off   = vlan ? IP_OFF_TAGGED : IP_OFF_UNTAGGED;
        hdr_idx  = cnt - ip_off;
        hdr_len  = {10'd0, ihl, 2'b00};
        in_hdr   = (cnt == ip_off) | (ip_ok & (cnt > ip_off) & (hdr_idx < hdr_len));
        byte_fwd = s_axis_tdata;
`ifdef LOOP_TTL_DEC_EN
        if (ip_ok && (cnt == ip_off + IP_TTL_OFF) && (s_axis_tdata != 8'h00))
            byte_fwd = s_axis_tdata - 8'd1;
`endif
        if ((hdr_idx == IP_CSUM_OFF) || (hdr_idx == IP_CSUM_OFF + 16'd1))
            add_word = 16'h0000;
        else if (hdr_idx[0])
            add_word = {8'h00, byte_fwd};
        else
            add_word = {byte_fwd, 8'h00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            etype    <= '0;
            vlan     <= 1'b0;
            ip_ok    <= 1'b0;
            ihl      <= '0;
            hdr_done <= 1'b0;
            err      <= 1'b0;
        end else if (state == ST_FOLD) begin
            acc      <= '0;
            etype    <= '0;
            vlan     <= 1'b0;
            ip_ok    <= 1'b0;
            ihl      <= '0;
            hdr_done <= 1'b0;
            err      <= 1'b0;
        end else if (beat) begin
            if (s_axis_tlast)
                cnt <= '0;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
            if (s_axis_tuser)
                err <= 1'b1;
            if (cnt == 16'd12)
                etype[15:8] <= s_axis_tdata;
            if (cnt == 16'd13) begin
                etype[7:0] <= s_axis_tdata;
                vlan       <= ({etype[15:8], s_axis_tdata} == ETHERTYPE_VLAN);
            end
            if (vlan && cnt == 16'd16)
                etype[15:8] <= s_axis_tdata;
            if (vlan && cnt == 16'd17)
                etype[7:0] <= s_axis_tdata;
            if (cnt == ip_off) begin
                ip_ok <= (etype == ETHERTYPE_IPV4) && (s_axis_tdata[7:4] == 4'd4)
                         && (s_axis_tdata[3:0] >= 4'd5);
                ihl   <= s_axis_tdata[3:0];
            end
            if (in_hdr)
                acc <= acc + {5'd0, add_word};
            if (ip_ok && in_hdr && (hdr_idx == hdr_len - 16'd1))
                hdr_done <= 1'b1;
        end
    end

    eth_csum_fold u_fold (
        .acc (acc),
        .sum (fold_sum)
    );

    always_comb begin
        csum    = ~fold_sum;
        fix     = ip_ok & hdr_done & ~err;
        desc_nx = '0;
        if (fix) begin
            desc_nx.csum = {csum[7:0], csum[15:8]};
            desc_nx.pos  = csum_pos(ip_off);
            desc_nx.fix  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_FRAME;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FRAME: if (beat && s_axis_tlast) state_nx = ST_FOLD;
            ST_FOLD:  state_nx = ST_FRAME;
            default:  state_nx = ST_FRAME;
        endcase
    end

    // The slot is always empty in FOLD: the last beat only enters when it is free or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            desc      <= '0;
            desc_full <= 1'b0;
        end else if (state == ST_FOLD) begin
            desc      <= desc_nx;
            desc_full <= 1'b1;
        end else if (desc_full && m_axis_csum_tready) begin
            desc_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_eth_frame_loop_rx.sv
// Directed self-checking bench for eth_frame_loop_rx (expectations follow LOOP_TTL_DEC_EN).
module tb_eth_frame_loop_rx;

`ifdef LOOP_TTL_DEC_EN
    localparam bit          TTL_ON = 1'b1;
    localparam logic [31:0] E_UNT  = 32'h61B9_0019;
    localparam logic [31:0] E_VLAN = 32'h61B9_001D;
`else
    localparam bit          TTL_ON = 1'b0;
    localparam logic [31:0] E_UNT  = 32'h61B8_0019;
    localparam logic [31:0] E_VLAN = 32'h61B8_001D;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tuser, s_tlast, s_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_frame_tdata;
    logic        m_axis_frame_tuser, m_axis_frame_tlast, m_axis_frame_tvalid;
    logic        frame_rdy;
    logic [31:0] m_axis_csum_tdata;
    logic        m_axis_csum_tvalid;
    logic        csum_rdy;

    int total = 0;
    int bad   = 0;
    bit bp_mode = 1'b0;

    logic [7:0]  frm [0:127];
    logic [7:0]  hdr [0:19] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                                8'h40, 8'h11, 8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01,
                                8'hC0, 8'hA8, 8'h00, 8'hC7};
    int flen;
    int ttl_idx;
    int cur_user;
    logic [9:0]  out_q [$];
    logic [31:0] desc_q [$];

    eth_frame_loop_rx dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_tdata        (s_tdata),
        .s_axis_tuser        (s_tuser),
        .s_axis_tlast        (s_tlast),
        .s_axis_tvalid       (s_tvalid),
        .s_axis_tready       (s_axis_tready),
        .m_axis_frame_tdata  (m_axis_frame_tdata),
        .m_axis_frame_tuser  (m_axis_frame_tuser),
        .m_axis_frame_tlast  (m_axis_frame_tlast),
        .m_axis_frame_tvalid (m_axis_frame_tvalid),
        .m_axis_frame_tready (frame_rdy),
        .m_axis_csum_tdata   (m_axis_csum_tdata),
        .m_axis_csum_tvalid  (m_axis_csum_tvalid),
        .m_axis_csum_tready  (csum_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (m_axis_frame_tvalid && frame_rdy)
            out_q.push_back({m_axis_frame_tlast, m_axis_frame_tuser, m_axis_frame_tdata});
        if (m_axis_csum_tvalid && csum_rdy)
            desc_q.push_back(m_axis_csum_tdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build(input bit vlan, input logic [15:0] et, input logic [7:0] vih, input int len);
        int off;
        for (int i = 0; i < 128; i++) frm[i] = 8'(i * 13 + 5);
        off = vlan ? 18 : 14;
        if (vlan) begin
            frm[12] = 8'h81; frm[13] = 8'h00; frm[14] = 8'h00; frm[15] = 8'h05;
            frm[16] = et[15:8]; frm[17] = et[7:0];
        end else begin
            frm[12] = et[15:8]; frm[13] = et[7:0];
        end
        for (int j = 0; j < 20; j++) frm[off + j] = hdr[j];
        frm[off] = vih;
        flen     = len;
        ttl_idx  = off + 8;
        cur_user = -1;
    endtask

    task automatic accept(input string tag);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            got = s_axis_tready;
            @(posedge clk);
            #1;
            if (bp_mode) frame_rdy = 1'($urandom_range(0, 1));
            n++;
        end
        if (!got) check({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            s_tdata  = frm[i];
            s_tuser  = (i == cur_user);
            s_tlast  = (i == flen - 1);
            s_tvalid = 1'b1;
            accept("accept");
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input bit dec);
        logic [9:0] e;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_len"}, out_q.size(), flen);
        for (int i = 0; i < flen && i < out_q.size(); i++) begin
            e = {(i == flen - 1), (i == cur_user), frm[i]};
            if (TTL_ON && dec && i == ttl_idx) e[7:0] = frm[i] - 8'd1;
            check({tag, "_byte"}, {22'd0, out_q[i]}, {22'd0, e});
        end
        out_q.delete();
    endtask

    task automatic expect_desc(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (desc_q.size() == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_desc_present"}, 32'(desc_q.size() > 0), 32'd1);
        if (desc_q.size() > 0) check({tag, "_desc"}, desc_q.pop_front(), exp);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] exp, input bit dec);
        send(flen);
        expect_desc(tag, exp);
        check_frame(tag, dec);
        check({tag, "_one_desc"}, desc_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b0;
        frame_rdy = 1'b1; csum_rdy = 1'b1;
        flen = 0; ttl_idx = 0; cur_user = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_csum_valid", m_axis_csum_tvalid, 0);
        check("rst_csum_data", m_axis_csum_tdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", s_axis_tready, 1);
        @(posedge clk); #1;

        // Untagged IPv4 with explicit latency checks.
        build(1'b0, 16'h0800, 8'h45, 60);
        send(flen);
        check("unt_fold_tready", s_axis_tready, 0);
        check("unt_lat1_valid", m_axis_csum_tvalid, 0);
        @(posedge clk); #1;
        check("unt_lat2_valid", m_axis_csum_tvalid, 1);
        check("unt_lat2_data", m_axis_csum_tdata, E_UNT);
        expect_desc("unt", E_UNT);
        check_frame("unt", 1'b1);
        check("unt_one_desc", desc_q.size(), 0);

        build(1'b1, 16'h0800, 8'h45, 64);
        run_frame("vlan", E_VLAN, 1'b1);

        build(1'b0, 16'h0806, 8'h45, 64);
        run_frame("arp", 32'h0, 1'b0);

        build(1'b0, 16'h0800, 8'h45, 20);
        run_frame("runt", 32'h0, 1'b0);

        build(1'b0, 16'h0800, 8'h44, 60);
        run_frame("bad_ihl", 32'h0, 1'b0);

        build(1'b0, 16'h0800, 8'h45, 60);
        cur_user = 40;
        run_frame("tuser", 32'h0, 1'b1);

        // Back-to-back with the descriptor slot held full.
        csum_rdy = 1'b0;
        build(1'b0, 16'h0800, 8'h45, 60);
        send(flen);
        check_frame("b2b_a", 1'b1);
        check("b2b_pending", m_axis_csum_tvalid, 1);
        build(1'b1, 16'h0800, 8'h45, 64);
        send(flen - 1);
        s_tdata = frm[flen - 1]; s_tlast = 1'b1; s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("b2b_stall", s_axis_tready, 0);
        end
        check("b2b_held_desc", m_axis_csum_tdata, E_UNT);
        @(posedge clk); #1;
        csum_rdy = 1'b1;
        accept("b2b_last");
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check_frame("b2b_b", 1'b1);
        expect_desc("b2b_first", E_UNT);
        expect_desc("b2b_second", E_VLAN);

        // Random frame backpressure.
        bp_mode = 1'b1;
        build(1'b0, 16'h0800, 8'h45, 60);
        run_frame("bp", E_UNT, 1'b1);
        bp_mode = 1'b0;
        frame_rdy = 1'b1;

        // Reset in the middle of a frame discards it.
        build(1'b0, 16'h0800, 8'h45, 60);
        send(30);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_valid", m_axis_csum_tvalid, 0);
        rst_n = 1'b1;
        out_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_desc", desc_q.size(), 0);
        run_frame("after_rst", E_UNT, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
